// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One op is in flight at a time; the result returns on the owner's response channel.
module alu_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             alu_cin_q, alu_cin_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             grant_s;
    logic             hs_s;
    logic             rsp_hs_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin pick: prio only matters when both requesters contend
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = prio_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Output decode: ready only in IDLE, response valid only for the owner in RESP
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = result_q;
        rsp1_data  = result_q;
        case (state_q)
            ST_IDLE: begin
                req0_ready = req0_valid && !grant_s;
                req1_ready = req1_valid && grant_s;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
        endcase
    end

    assign hs_s     = req0_ready || req1_ready;
    assign rsp_hs_s = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: operands load only on an op handshake and otherwise hold
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_cin_d = alu_cin_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        result_d  = result_q;
        if (hs_s) begin
            owner_d = grant_s;
            if (grant_s) begin
                alu_a_d   = req1_a;
                alu_b_d   = req1_b;
                alu_op_d  = req1_op;
                alu_cin_d = req1_cin;
            end else begin
                alu_a_d   = req0_a;
                alu_b_d   = req0_b;
                alu_op_d  = req0_op;
                alu_cin_d = req0_cin;
            end
        end else begin
            owner_d = owner_q;
        end
        if (state_q == ST_ISSUE) begin
            result_d = alu_out;
        end else begin
            result_d = result_q;
        end
        // The requester just served yields priority to the other one
        if (rsp_hs_s) begin
            prio_d = !owner_q;
        end else begin
            prio_d = prio_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q   <= {WIDTH{1'b0}};
            alu_b_q   <= {WIDTH{1'b0}};
            alu_op_q  <= {OPW{1'b0}};
            alu_cin_q <= 1'b0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            result_q  <= result_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign alu_cin = alu_cin_q;

endmodule
